// File: rtl/lfsr_ctrl.sv
// ----------------------------------------------------------------------------
// lfsr_ctrl
//
// Host-side sequencer for an external LFSR. A host start request latches a
// seed and a shift length, loads the seed into the LFSR through a one-cycle
// active-low lfsr_rst pulse, lets it settle, advances it shift_len times, and
// then collects LFSR_WIDTH serial bits (LSB first) into data. A missing or
// interrupted lfsr_valid stream ends the transaction with err=1.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   rst             : asynchronous active-low reset
//   start           : host request pulse, only honoured while idle
//   seed            : seed word, latched when start is accepted
//   shift_len       : number of LFSR shift cycles, latched with seed
//   busy            : high whenever a transaction is in progress
//   done            : one-cycle completion pulse
//   err             : status qualifying done, held until the next done
//   data            : captured word, held until the next done
//   lfsr_seed       : latched seed presented to the LFSR
//   lfsr_rst        : active-low LFSR load/reset strobe
//   lfsr_enable     : LFSR shift enable
//   lfsr_out_enable : request for LFSR serial output
//   lfsr_out        : LFSR serial data
//   lfsr_valid      : qualifies lfsr_out
// ----------------------------------------------------------------------------
module lfsr_ctrl #(
    parameter int LFSR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LFSR_WIDTH-1:0] seed,
    input  logic [4:0]            shift_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LFSR_WIDTH-1:0] data,
    output logic [LFSR_WIDTH-1:0] lfsr_seed,
    output logic                  lfsr_rst,
    output logic                  lfsr_enable,
    output logic                  lfsr_out_enable,
    input  logic                  lfsr_out,
    input  logic                  lfsr_valid
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(LFSR_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SHIFT,
        WAIT_VALID,
        CAPTURE,
        DONE
    } state_t;

    state_t                state, state_nxt;
    logic [4:0]            shift_cnt, shift_cnt_nxt;
    logic [TW-1:0]         wait_cnt, wait_cnt_nxt;
    logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
    logic [LFSR_WIDTH-1:0] shreg, shreg_nxt;
    logic [LFSR_WIDTH-1:0] data_nxt, seed_nxt;
    logic                  err_nxt;

    // Next-state and next-datapath logic. Every output is registered from
    // the next state, so the outputs line up exactly with the state they
    // belong to. Bits enter at the top of shreg and move down, so after
    // LFSR_WIDTH shifts the first bit received sits at bit 0.
    always_comb begin
        state_nxt     = state;
        shift_cnt_nxt = shift_cnt;
        wait_cnt_nxt  = wait_cnt;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        data_nxt      = data;
        err_nxt       = err;
        seed_nxt      = lfsr_seed;

        case (state)
            IDLE: begin
                if (start) begin
                    seed_nxt      = seed;
                    shift_cnt_nxt = shift_len;
                    state_nxt     = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SETTLE;
            end
            SETTLE: begin
                wait_cnt_nxt = '0;
                if (shift_cnt == 5'd0) begin
                    state_nxt = WAIT_VALID;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_cnt_nxt = shift_cnt - 5'd1;
                wait_cnt_nxt  = '0;
                if (shift_cnt == 5'd1) begin
                    state_nxt = WAIT_VALID;
                end
            end
            WAIT_VALID: begin
                if (lfsr_valid) begin
                    shreg_nxt   = {lfsr_out, shreg[LFSR_WIDTH-1:1]};
                    bit_cnt_nxt = BW'(1);
                    state_nxt   = CAPTURE;
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    data_nxt  = '0;
                    state_nxt = DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt + TW'(1);
                end
            end
            CAPTURE: begin
                if (!lfsr_valid) begin
                    // Interrupted stream: flag it and keep the old word.
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    shreg_nxt = {lfsr_out, shreg[LFSR_WIDTH-1:1]};
                    if (bit_cnt == BW'(LFSR_WIDTH - 1)) begin
                        data_nxt  = {lfsr_out, shreg[LFSR_WIDTH-1:1]};
                        err_nxt   = 1'b0;
                        state_nxt = DONE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            DONE: begin
                shift_cnt_nxt = '0;
                wait_cnt_nxt  = '0;
                bit_cnt_nxt   = '0;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs. lfsr_rst is low during reset
    // and for the single LOAD cycle, high everywhere else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            shift_cnt       <= '0;
            wait_cnt        <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            data            <= '0;
            err             <= 1'b0;
            lfsr_seed       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            lfsr_rst        <= 1'b0;
            lfsr_enable     <= 1'b0;
            lfsr_out_enable <= 1'b0;
        end else begin
            state           <= state_nxt;
            shift_cnt       <= shift_cnt_nxt;
            wait_cnt        <= wait_cnt_nxt;
            bit_cnt         <= bit_cnt_nxt;
            shreg           <= shreg_nxt;
            data            <= data_nxt;
            err             <= err_nxt;
            lfsr_seed       <= seed_nxt;
            busy            <= (state_nxt != IDLE);
            done            <= (state_nxt == DONE);
            lfsr_rst        <= (state_nxt != LOAD);
            lfsr_enable     <= (state_nxt == SHIFT);
            lfsr_out_enable <= (state_nxt == WAIT_VALID) || (state_nxt == CAPTURE);
        end
    end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lfsr_ctrl
//
// Bench for lfsr_ctrl with a behavioural 8-bit Fibonacci LFSR
// (x^8 + x^6 + x^5 + x^4 + 1) attached to the LFSR-side ports. Each
// transaction pushes its expected outcome to a scoreboard queue when start
// is driven and pops it when done is observed.
// ----------------------------------------------------------------------------
module tb_lfsr_ctrl;

    localparam int W  = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] seed;
    logic [4:0]   shift_len;
    logic         busy, done, err;
    logic [W-1:0] data, lfsr_seed;
    logic         lfsr_rst, lfsr_enable, lfsr_out_enable;
    logic         lfsr_out, lfsr_valid;

    lfsr_ctrl #(.LFSR_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .seed           (seed),
        .shift_len      (shift_len),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .data           (data),
        .lfsr_seed      (lfsr_seed),
        .lfsr_rst       (lfsr_rst),
        .lfsr_enable    (lfsr_enable),
        .lfsr_out_enable(lfsr_out_enable),
        .lfsr_out       (lfsr_out),
        .lfsr_valid     (lfsr_valid)
    );

    always #5 clk = ~clk;

    // Behavioural LFSR: loads while lfsr_rst is low, steps on lfsr_enable,
    // serialises its state LSB first, and offers only valid_limit bits.
    logic [W-1:0] lfsr_s;
    logic [3:0]   bit_idx;
    int           valid_limit = W;

    function automatic logic [W-1:0] lfsrStep(input logic [W-1:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [W-1:0] lfsrAfter(input logic [W-1:0] s, input int n);
        logic [W-1:0] r;
        r = s;
        for (int i = 0; i < n; i++) r = lfsrStep(r);
        return r;
    endfunction

    always @(posedge clk) begin
        if (!lfsr_rst) begin
            lfsr_s  <= lfsr_seed;
            bit_idx <= '0;
        end else begin
            if (lfsr_enable) lfsr_s <= lfsrStep(lfsr_s);
            if (lfsr_out_enable && lfsr_valid) bit_idx <= bit_idx + 4'd1;
        end
    end

    assign lfsr_out   = lfsr_s[bit_idx[2:0]];
    assign lfsr_valid = lfsr_out_enable && (int'(bit_idx) < valid_limit);

    typedef struct {
        logic [W-1:0] seed;
        logic [4:0]   len;
        int           limit;
        logic         exp_err;
        int           inject_at;
    } vec_t;

    typedef struct {
        logic         err;
        logic [W-1:0] data;
        int           latency;
        int           en_cycles;
        int           oe_cycles;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_data = '0;
    vec_t         vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e, got_e;
        int   lat, en, rl, oe, seed_bad;
        bit   got;
        e.err       = v.exp_err;
        e.en_cycles = int'(v.len);
        if (v.limit == 0) begin
            e.data      = '0;
            e.latency   = 4 + int'(v.len) + TO;
            e.oe_cycles = TO;
        end else if (v.limit >= W) begin
            e.data      = lfsrAfter(v.seed, int'(v.len));
            e.latency   = 4 + int'(v.len) + W;
            e.oe_cycles = W;
        end else begin
            e.data      = last_data;
            e.latency   = 5 + int'(v.len) + v.limit;
            e.oe_cycles = v.limit + 1;
        end
        last_data = e.data;
        sb.push_back(e);

        valid_limit = v.limit;
        @(negedge clk);
        seed      = v.seed;
        shift_len = v.len;
        start     = 1'b1;
        lat = 1; en = 0; rl = 0; oe = 0; seed_bad = 0; got = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            lat++;
            if (lat == v.inject_at) begin
                seed  = 8'hFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (lfsr_enable) en++;
            if (!lfsr_rst) rl++;
            if (lfsr_out_enable) oe++;
            if (busy && lfsr_seed !== v.seed) seed_bad++;
            if (done) begin
                got = 1;
                break;
            end
        end
        start = 1'b0;

        got_e = sb.pop_front();
        checkOutput("done_seen", 32'(got), 32'd1);
        checkOutput("err", 32'(err), 32'(got_e.err));
        checkOutput("data", 32'(data), 32'(got_e.data));
        checkOutput("latency", 32'(lat), 32'(got_e.latency));
        checkOutput("enable_cycles", 32'(en), 32'(got_e.en_cycles));
        checkOutput("out_enable_cycles", 32'(oe), 32'(got_e.oe_cycles));
        checkOutput("lfsr_rst_low_cycles", 32'(rl), 32'd1);
        checkOutput("seed_stable", 32'(seed_bad), 32'd0);
        checkOutput("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("idle_after_done", 32'(busy), 32'd0);
        checkOutput("err_held", 32'(err), 32'(got_e.err));
    endtask

    function automatic logic [31:0] packOutputs();
        return 32'({busy, done, err, data, lfsr_seed, lfsr_rst, lfsr_enable, lfsr_out_enable});
    endfunction

    initial begin
        vecs[0] = '{8'h93, 5'd10, 8, 1'b0, 0};
        vecs[1] = '{8'h01, 5'd0,  8, 1'b0, 0};
        vecs[2] = '{8'hA5, 5'd31, 8, 1'b0, 0};
        vecs[3] = '{8'h3E, 5'd7,  5, 1'b1, 0};
        vecs[4] = '{8'h5C, 5'd3,  0, 1'b1, 0};
        vecs[5] = '{8'hC3, 5'd1,  8, 1'b0, 0};
        vecs[6] = '{8'h77, 5'd2,  7, 1'b1, 0};
        vecs[7] = '{8'h00, 5'd4,  1, 1'b1, 0};
        vecs[8] = '{8'h93, 5'd10, 8, 1'b0, 5};

        rst = 1'b0; start = 1'b0; seed = '0; shift_len = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", packOutputs(), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("lfsr_rst_after_reset", 32'(lfsr_rst), 32'd1);
        checkOutput("idle_after_reset", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

        // Abort in the middle of CAPTURE, then rerun the same transaction.
        valid_limit = W;
        @(negedge clk);
        seed = 8'h93; shift_len = 5'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("in_capture_before_abort", 32'({busy, lfsr_out_enable}), 32'b11);
        #2 rst = 1'b0;
        #1 checkOutput("async_abort_outputs", packOutputs(), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("no_done_in_abort", 32'(done), 32'd0);
        end
        rst = 1'b1;
        last_data = '0;
        @(negedge clk);
        checkOutput("lfsr_rst_after_abort", 32'(lfsr_rst), 32'd1);
        applyStimulus(vecs[0]);

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
